// File: rtl/decode_stage_hz.sv
// decode_stage_hz: ID stage with register file, control decode, immediate extension and a hazard-aware ID/EX register.
// Defining DECODE_BYPASS_EN makes a coincident writeback visible to the same-cycle register read.
module decode_stage_hz #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int BCNT_W = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FlushE,
    input  logic              StallE,
    input  logic              ValidD,
    input  logic              RegWriteW,
    input  logic [AW-1:0]     RDW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    output logic              StallF,
    output logic              StallD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              ALUSrcE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              JumpE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [AW-1:0]     RS1_E,
    output logic [AW-1:0]     RS2_E,
    output logic [AW-1:0]     RD_E,
    output logic [BCNT_W-1:0] BubbleCnt
);
    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            aluSrc;
        logic            memWrite;
        logic            branch;
        logic            jump;
        logic [1:0]      resultSrc;
        logic [2:0]      aluCtrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
    } idex_t;

    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rs1D, rs2D;
    logic [XLEN-1:0] rd1D, rd2D, immD;
    logic            regWriteD, aluSrcD, memWriteD, branchD, jumpD, luHaz;
    logic [1:0]      resultSrcD, aluOpD;
    logic [2:0]      immSrcD, aluCtrlD, funct3;
    idex_t           idexD, idexQ;

    assign rs1D   = InstrD[15 +: AW];
    assign rs2D   = InstrD[20 +: AW];
    assign funct3 = InstrD[14:12];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (RegWriteW && RDW != '0) begin
            regs[RDW] <= ResultW;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign rd1D = rs1D == '0 ? '0 : (RegWriteW && RDW == rs1D) ? ResultW : regs[rs1D];
    assign rd2D = rs2D == '0 ? '0 : (RegWriteW && RDW == rs2D) ? ResultW : regs[rs2D];
`else
    assign rd1D = rs1D == '0 ? '0 : regs[rs1D];
    assign rd2D = rs2D == '0 ? '0 : regs[rs2D];
`endif

    always_comb begin
        regWriteD  = 1'b0;
        aluSrcD    = 1'b0;
        memWriteD  = 1'b0;
        branchD    = 1'b0;
        jumpD      = 1'b0;
        resultSrcD = 2'b00;
        aluOpD     = 2'b00;
        immSrcD    = 3'b000;
        case (InstrD[6:0])
            7'b0000011: begin regWriteD = 1'b1; aluSrcD = 1'b1; resultSrcD = 2'b01; end
            7'b0100011: begin memWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = 3'b001; end
            7'b0110011: begin regWriteD = 1'b1; aluOpD = 2'b10; end
            7'b0010011: begin regWriteD = 1'b1; aluSrcD = 1'b1; aluOpD = 2'b10; end
            7'b1100011: begin branchD = 1'b1; aluOpD = 2'b01; immSrcD = 3'b010; end
            7'b1101111: begin regWriteD = 1'b1; jumpD = 1'b1; resultSrcD = 2'b10; immSrcD = 3'b011; end
            7'b0110111: begin regWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = 3'b100; end
            default: ;
        endcase
    end

    // Subtract only for R-type funct7[5]; I-type reuses bit 30 as immediate.
    assign aluCtrlD = aluOpD == 2'b00 ? 3'b000 :
                      aluOpD == 2'b01 ? 3'b001 :
                      funct3 == 3'b000 ? ((InstrD[5] & InstrD[30]) ? 3'b001 : 3'b000) :
                      funct3 == 3'b010 ? 3'b101 :
                      funct3 == 3'b110 ? 3'b011 :
                      funct3 == 3'b111 ? 3'b010 : 3'b000;

    assign immD = immSrcD == 3'b000 ? XLEN'($signed(InstrD[31:20])) :
                  immSrcD == 3'b001 ? XLEN'($signed({InstrD[31:25], InstrD[11:7]})) :
                  immSrcD == 3'b010 ? XLEN'($signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0})) :
                  immSrcD == 3'b011 ? XLEN'($signed({InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0})) :
                  immSrcD == 3'b100 ? XLEN'($signed({InstrD[31:12], 12'b0})) : '0;

    assign luHaz  = ValidE && ResultSrcE == 2'b01 && RD_E != '0 && ValidD && (RD_E == rs1D || RD_E == rs2D);
    assign StallF = rst & (luHaz | StallE);
    assign StallD = StallF;

    always_comb begin
        idexD           = '0;
        idexD.valid     = ValidD;
        idexD.regWrite  = regWriteD & ValidD;
        idexD.aluSrc    = aluSrcD & ValidD;
        idexD.memWrite  = memWriteD & ValidD;
        idexD.branch    = branchD & ValidD;
        idexD.jump      = jumpD & ValidD;
        idexD.resultSrc = ValidD ? resultSrcD : 2'b00;
        idexD.aluCtrl   = ValidD ? aluCtrlD : 3'b000;
        idexD.rd1       = rd1D;
        idexD.rd2       = rd2D;
        idexD.imm       = immD;
        idexD.pc        = PCD;
        idexD.pc4       = PCPlus4D;
        idexD.rs1       = rs1D;
        idexD.rs2       = rs2D;
        idexD.rd        = InstrD[7 +: AW];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idexQ     <= '0;
            BubbleCnt <= '0;
        end else if (FlushE) begin
            idexQ <= '0;
        end else if (!StallE) begin
            if (luHaz) begin
                idexQ <= '0;
                if (BubbleCnt != '1) BubbleCnt <= BubbleCnt + BCNT_W'(1);
            end else begin
                idexQ <= idexD;
            end
        end
    end

    assign ValidE      = idexQ.valid;
    assign RegWriteE   = idexQ.regWrite;
    assign ALUSrcE     = idexQ.aluSrc;
    assign MemWriteE   = idexQ.memWrite;
    assign BranchE     = idexQ.branch;
    assign JumpE       = idexQ.jump;
    assign ResultSrcE  = idexQ.resultSrc;
    assign ALUControlE = idexQ.aluCtrl;
    assign RD1_E       = idexQ.rd1;
    assign RD2_E       = idexQ.rd2;
    assign Imm_Ext_E   = idexQ.imm;
    assign PCE         = idexQ.pc;
    assign PCPlus4E    = idexQ.pc4;
    assign RS1_E       = idexQ.rs1;
    assign RS2_E       = idexQ.rs2;
    assign RD_E        = idexQ.rd;
endmodule

// File: tb/tb_decode_stage_hz.sv
// tb_decode_stage_hz: directed scoreboard bench for decode_stage_hz (default 32-bit configuration).
module tb_decode_stage_hz;
    logic        clk = 0, rst = 0;
    logic        FlushE = 0, StallE = 0, ValidD = 0, RegWriteW = 0;
    logic [4:0]  RDW = 0;
    logic [31:0] ResultW = 0, InstrD = 0, PCD = 0, PCPlus4D = 0;
    logic        StallF, StallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic [15:0] BubbleCnt;
    int checks = 0, errors = 0;

    typedef struct {
        string       tag;
        logic        v, rw, mw;
        logic [1:0]  rsrc;
        logic [2:0]  alu;
        logic [31:0] a, b, imm, pc;
        logic        ci;
        logic [4:0]  rd;
        logic [15:0] bc;
    } exp_t;
    exp_t sb[$];

    decode_stage_hz dut (
        .clk(clk), .rst(rst), .FlushE(FlushE), .StallE(StallE), .ValidD(ValidD),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .StallF(StallF), .StallD(StallD), .ValidE(ValidE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1_E(RD1_E),
        .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RS1_E(RS1_E),
        .RS2_E(RS2_E), .RD_E(RD_E), .BubbleCnt(BubbleCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(string t, logic v, logic rw, logic mw, logic [1:0] rsrc, logic [2:0] alu,
                        logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic ci, logic [4:0] rd,
                        logic [31:0] pc, logic [15:0] bc);
        exp_t e;
        e.tag = t; e.v = v; e.rw = rw; e.mw = mw; e.rsrc = rsrc; e.alu = alu;
        e.a = a; e.b = b; e.imm = imm; e.ci = ci; e.rd = rd; e.pc = pc; e.bc = bc;
        sb.push_back(e);
    endtask

    task automatic bubble(string t, logic [15:0] bc);
        push(t, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0, 0, bc);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".valid"}, 32'(ValidE), 32'(e.v));
            chk({e.tag, ".regwrite"}, 32'(RegWriteE), 32'(e.rw));
            chk({e.tag, ".memwrite"}, 32'(MemWriteE), 32'(e.mw));
            chk({e.tag, ".resultsrc"}, 32'(ResultSrcE), 32'(e.rsrc));
            chk({e.tag, ".aluctrl"}, 32'(ALUControlE), 32'(e.alu));
            chk({e.tag, ".rd1"}, RD1_E, e.a);
            chk({e.tag, ".rd2"}, RD2_E, e.b);
            if (e.ci) chk({e.tag, ".imm"}, Imm_Ext_E, e.imm);
            chk({e.tag, ".rd"}, 32'(RD_E), 32'(e.rd));
            chk({e.tag, ".pc"}, PCE, e.pc);
            chk({e.tag, ".bubbles"}, 32'(BubbleCnt), 32'(e.bc));
        end
    endtask

    task automatic dec(logic [31:0] instr, logic [31:0] pc);
        InstrD = instr; PCD = pc; PCPlus4D = pc + 4; ValidD = 1;
    endtask

    function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    logic [31:0] addX6, subX13, addiX9, swX5, luiX10, lwX7, addX8, addX12;
    logic [31:0] bypExp;

    initial begin
        addX6  = rtype(7'h00, 5'd5, 5'd5, 5'd6);
        subX13 = rtype(7'h20, 5'd5, 5'd0, 5'd13);
        addiX9 = {12'hFFB, 5'd0, 3'b000, 5'd9, 7'b0010011};
        swX5   = {7'h7F, 5'd5, 5'd2, 3'b010, 5'h18, 7'b0100011};
        luiX10 = {20'h12345, 5'd10, 7'b0110111};
        lwX7   = {12'h000, 5'd1, 3'b010, 5'd7, 7'b0000011};
        addX8  = rtype(7'h00, 5'd2, 5'd7, 5'd8);
        addX12 = rtype(7'h00, 5'd0, 5'd3, 5'd12);
`ifdef DECODE_BYPASS_EN
        bypExp = 32'h0000_1234;
`else
        bypExp = 32'h0;
`endif
        // reset state, StallE asserted to confirm the stall is masked in reset
        StallE = 1;
        @(posedge clk);
        #1;
        chk("rst.valid", 32'(ValidE), 0);
        chk("rst.rd1", RD1_E, 0);
        chk("rst.bubbles", 32'(BubbleCnt), 0);
        chk("rst.stallf", 32'(StallF), 0);
        StallE = 0;
        @(negedge clk);
        rst = 1;
        // writeback x5, then an attempted write of x0
        RegWriteW = 1; RDW = 5; ResultW = 32'hDEAD_BEEF;
        bubble("wb_x5", 0);
        tick();
        RDW = 0; ResultW = 32'hFFFF_FFFF;
        bubble("wb_x0", 0);
        tick();
        RegWriteW = 0;
        dec(addX6, 100);
        push("add_x6", 1, 1, 0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 6, 100, 0);
        tick();
        dec(subX13, 104);
        push("sub_x0", 1, 1, 0, 2'b00, 3'b001, 0, 32'hDEAD_BEEF, 0, 0, 13, 104, 0);
        tick();
        dec(addiX9, 108);
        push("addi", 1, 1, 0, 2'b00, 3'b000, 0, 0, 32'hFFFF_FFFB, 1, 9, 108, 0);
        tick();
        dec(swX5, 112);
        push("sw", 1, 0, 1, 2'b00, 3'b000, 0, 32'hDEAD_BEEF, 32'hFFFF_FFF8, 1, 24, 112, 0);
        tick();
        dec(luiX10, 116);
        push("lui", 1, 1, 0, 2'b00, 3'b000, 0, 0, 32'h1234_5000, 1, 10, 116, 0);
        tick();
        // load-use: lw x7 then add x8,x7,x2
        dec(lwX7, 120);
        push("lw", 1, 1, 0, 2'b01, 3'b000, 0, 0, 0, 1, 7, 120, 0);
        tick();
        dec(addX8, 124);
        #1;
        chk("lu.stallf", 32'(StallF), 1);
        chk("lu.stalld", 32'(StallD), 1);
        bubble("lu_bubble", 1);
        tick();
        chk("lu.stallf_drop", 32'(StallF), 0);
        push("lu_add", 1, 1, 0, 2'b00, 3'b000, 0, 0, 0, 0, 8, 124, 1);
        tick();
        // flush beats stall and load-use; counter untouched
        dec(lwX7, 128);
        push("lw2", 1, 1, 0, 2'b01, 3'b000, 0, 0, 0, 1, 7, 128, 1);
        tick();
        dec(addX8, 132);
        FlushE = 1; StallE = 1;
        #1;
        chk("prio.stallf", 32'(StallF), 1);
        bubble("flush_prio", 1);
        tick();
        FlushE = 0; StallE = 0;
        // hold for three cycles
        dec(addX6, 136);
        push("hold_load", 1, 1, 0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 6, 136, 1);
        tick();
        StallE = 1;
        dec(addiX9, 140);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold.stalld", 32'(StallD), 1);
            push("hold", 1, 1, 0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 6, 136, 1);
            tick();
        end
        StallE = 0;
        // coincident writeback and read of x3
        RegWriteW = 1; RDW = 3; ResultW = 32'h0000_1234;
        dec(addX12, 144);
        push("bypass", 1, 1, 0, 2'b00, 3'b000, bypExp, 0, 0, 0, 12, 144, 1);
        tick();
        RegWriteW = 0;
        dec(addX12, 148);
        push("after_wb", 1, 1, 0, 2'b00, 3'b000, 32'h0000_1234, 0, 0, 0, 12, 148, 1);
        tick();
        // reset asserted while a load-use stall is active
        dec(lwX7, 152);
        push("lw3", 1, 1, 0, 2'b01, 3'b000, 0, 0, 0, 1, 7, 152, 1);
        tick();
        dec(addX8, 156);
        #1;
        chk("mid.stallf_pre", 32'(StallF), 1);
        #2;
        rst = 0;
        #1;
        chk("mid.valid", 32'(ValidE), 0);
        chk("mid.regwrite", 32'(RegWriteE), 0);
        chk("mid.resultsrc", 32'(ResultSrcE), 0);
        chk("mid.rd1", RD1_E, 0);
        chk("mid.pc", PCE, 0);
        chk("mid.rd", 32'(RD_E), 0);
        chk("mid.bubbles", 32'(BubbleCnt), 0);
        chk("mid.stallf", 32'(StallF), 0);
        chk("mid.stalld", 32'(StallD), 0);
        @(negedge clk);
        rst = 1;
        dec(addX6, 160);
        push("post_rst_rf", 1, 1, 0, 2'b00, 3'b000, 0, 0, 0, 0, 6, 160, 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
